opl3_timer_status: RTL and testbench

OPL3 timer block in the `clk` domain: owns Timer 1 (80 µs resolution) and Timer 2 (320 µs resolution), their overflow flags, the IRQ and the status byte returned on host status reads. It consumes decoded register writes and the synchronized `force_timer_overflow` pulse from the software-detection helper. On a forced overflow it sets the Timer 1 flag at once, so detection loops that poll faster than real hardware still see `0xC0`.

---
 rtl/opl3_pkg.sv | 22 ++
 rtl/opl3_timer_channel.sv | 37 +++
 rtl/opl3_timer_status.sv | 133 +++++++++++++
 tb/tb_opl3_timer_status.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared types and constants for the OPL3 timer/status block.
// Holds the register-write struct, the timer register addresses and the status bit positions.
package opl3_pkg;

    localparam int REG_TIMER_WIDTH = 8;

    localparam logic [7:0] TIMER1_ADDR     = 8'h02;
    localparam logic [7:0] TIMER2_ADDR     = 8'h03;
    localparam logic [7:0] TIMER_CTRL_ADDR = 8'h04;

    localparam int STATUS_IRQ_BIT = 7;
    localparam int STATUS_FT1_BIT = 6;
    localparam int STATUS_FT2_BIT = 5;

    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

endpackage

// File: rtl/opl3_timer_channel.sv
// One 8-bit up-counting OPL3 timer: loads from its preset on start, counts on tick,
// reloads at 0xFF and reports that reload as a single-cycle overflow pulse.
module opl3_timer_channel
    import opl3_pkg::*;
(
    input  logic                       clk,
    input  logic                       ic_n,
    input  logic                       tick,
    input  logic                       start_load,
    input  logic                       run,
    input  logic [REG_TIMER_WIDTH-1:0] preset,
    output logic                       overflow
);

    logic [REG_TIMER_WIDTH-1:0] count;
    logic                       at_max;

    assign at_max = (count == '1);

    // A load always beats a tick landing in the same cycle.
    assign overflow = tick && run && at_max && !start_load;

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            count <= '0;
        end else if (start_load) begin
            count <= preset;
        end else if (tick && run) begin
            if (at_max) begin
                count <= preset;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/opl3_timer_status.sv
// OPL3 timer block: prescaler, timer register decode, masks, sticky overflow flags,
// forced Timer 1 overflow for software detection, and the host status byte / IRQ.
module opl3_timer_status
    import opl3_pkg::*;
#(
    parameter int TICK_80US_CYCLES = 1145
) (
    input  logic         clk,
    input  logic         ic_n,
    input  opl3_reg_wr_t reg_wr,
    input  logic         force_timer_overflow,
    output logic [7:0]   status,
    output logic         irq_n
);

    localparam int PRE_W = (TICK_80US_CYCLES > 2) ? $clog2(TICK_80US_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_80US_CYCLES - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [1:0]       sub_cnt;
    logic             tick80;
    logic             tick320;

    logic [REG_TIMER_WIDTH-1:0] preset1;
    logic [REG_TIMER_WIDTH-1:0] preset2;
    logic mt1, mt2, st1, st2;
    logic ft1, ft2;
    logic force_d;

    logic wr_bank0, wr_ctrl, rst_cmd, ctrl_upd;
    logic start_load1, start_load2;
    logic ov1, ov2, force_edge;
    logic set_ft1, set_ft2, irq;
    logic unused_ok;

    // Free-running base tick; register writes never disturb its phase.
    assign tick80  = (pre_cnt == PRE_LAST);
    assign tick320 = tick80 && (sub_cnt == 2'd3);

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            pre_cnt <= '0;
            sub_cnt <= '0;
        end else if (tick80) begin
            pre_cnt <= '0;
            sub_cnt <= sub_cnt + 2'd1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // reg_wr is valid-only: every valid cycle is consumed, there is no backpressure.
    assign wr_bank0    = reg_wr.valid && !reg_wr.bank_num;
    assign wr_ctrl     = wr_bank0 && (reg_wr.address == TIMER_CTRL_ADDR);
    assign rst_cmd     = wr_ctrl && reg_wr.data[7];
    assign ctrl_upd    = wr_ctrl && !reg_wr.data[7];
    assign start_load1 = ctrl_upd && reg_wr.data[0] && !st1;
    assign start_load2 = ctrl_upd && reg_wr.data[1] && !st2;
    assign unused_ok   = ^reg_wr.data[4:2];

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            preset1 <= '0;
            preset2 <= '0;
            mt1     <= 1'b0;
            mt2     <= 1'b0;
            st1     <= 1'b0;
            st2     <= 1'b0;
        end else begin
            if (wr_bank0 && (reg_wr.address == TIMER1_ADDR)) preset1 <= reg_wr.data;
            if (wr_bank0 && (reg_wr.address == TIMER2_ADDR)) preset2 <= reg_wr.data;
            if (ctrl_upd) begin
                mt1 <= reg_wr.data[6];
                mt2 <= reg_wr.data[5];
                st2 <= reg_wr.data[1];
                st1 <= reg_wr.data[0];
            end
        end
    end

    opl3_timer_channel u_t1 (
        .clk        (clk),
        .ic_n       (ic_n),
        .tick       (tick80),
        .start_load (start_load1),
        .run        (st1),
        .preset     (preset1),
        .overflow   (ov1)
    );

    opl3_timer_channel u_t2 (
        .clk        (clk),
        .ic_n       (ic_n),
        .tick       (tick320),
        .start_load (start_load2),
        .run        (st2),
        .preset     (preset2),
        .overflow   (ov2)
    );

    // The forced edge mimics a Timer 1 overflow without touching the counter.
    assign force_edge = force_timer_overflow && !force_d;
    assign set_ft1    = !mt1 && (ov1 || (force_edge && st1));
    assign set_ft2    = !mt2 && ov2;

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            force_d <= 1'b0;
            ft1     <= 1'b0;
            ft2     <= 1'b0;
        end else begin
            force_d <= force_timer_overflow;
            if (rst_cmd) begin
                ft1 <= 1'b0;
                ft2 <= 1'b0;
            end else begin
                if (set_ft1) ft1 <= 1'b1;
                if (set_ft2) ft2 <= 1'b1;
            end
        end
    end

    assign irq   = ft1 || ft2;
    assign irq_n = !irq;

    always_comb begin
        status                 = '0;
        status[STATUS_IRQ_BIT] = irq;
        status[STATUS_FT1_BIT] = ft1;
        status[STATUS_FT2_BIT] = ft2;
    end

endmodule

// File: tb/tb_opl3_timer_status.sv
// Directed bench for opl3_timer_status with a 10-cycle base tick; a small prescaler model
// tells the bench where tick80/tick320 fall so expectations are exact.
module tb_opl3_timer_status;
    import opl3_pkg::*;

    localparam int TICK = 10;

    logic         clk = 1'b0;
    logic         ic_n = 1'b0;
    opl3_reg_wr_t reg_wr;
    logic         force_timer_overflow;
    logic [7:0]   status;
    logic         irq_n;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    int tb_pre = 0;
    int tb_sub = 0;

    // clock / reset
    always #5 clk = ~clk;

    opl3_timer_status #(.TICK_80US_CYCLES(TICK)) u_dut (
        .clk                  (clk),
        .ic_n                 (ic_n),
        .reg_wr               (reg_wr),
        .force_timer_overflow (force_timer_overflow),
        .status               (status),
        .irq_n                (irq_n)
    );

    // Reference prescaler: next posedge is a tick80 when tb_pre == TICK-1.
    always @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            tb_pre <= 0;
            tb_sub <= 0;
        end else if (tb_pre == TICK - 1) begin
            tb_pre <= 0;
            tb_sub <= (tb_sub + 1) % 4;
        end else begin
            tb_pre <= tb_pre + 1;
        end
    end

    // scoreboard
    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, e);
        end
    endtask

    // driver tasks (called at a negedge, return at a negedge)
    task automatic wr(input logic bank, input logic [7:0] addr, input logic [7:0] data);
        reg_wr.valid    = 1'b1;
        reg_wr.bank_num = bank;
        reg_wr.address  = addr;
        reg_wr.data     = data;
        @(negedge clk);
        reg_wr = '0;
    endtask

    task automatic wait_pre(input int value);
        int guard = 0;
        while (tb_pre != value && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pre: prescaler never reached %0d", value);
        end
    endtask

    task automatic wait_tick80();
        wait_pre(TICK - 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  n320;
        bit  hit;

        reg_wr               = '0;
        force_timer_overflow = 1'b0;
        repeat (2) @(negedge clk);
        check8("rst_status", status, 8'h00);
        check8("rst_irq_n", {7'b0, irq_n}, 8'h01);
        ic_n = 1'b1;
        @(negedge clk);

        // detection sequence
        wr(1'b0, 8'h04, 8'h60);
        wr(1'b0, 8'h04, 8'h80);
        check8("det_clear", status, 8'h00);
        wr(1'b0, 8'h02, 8'hFF);
        wr(1'b0, 8'h04, 8'h21);
        check8("det_before_tick", status, 8'h00);
        wait_tick80();
        check8("det_ovf", status, 8'hC0);
        check8("det_irq_n", {7'b0, irq_n}, 8'h00);
        wr(1'b0, 8'h04, 8'h60);
        wr(1'b0, 8'h04, 8'h80);
        check8("det_rst", status, 8'h00);

        // forced overflow, kept clear of any tick80
        wait_pre(0);
        wr(1'b0, 8'h02, 8'hFF);
        wr(1'b0, 8'h04, 8'h21);
        check8("frc_before", status, 8'h00);
        force_timer_overflow = 1'b1;
        @(negedge clk);
        check8("frc_set", status, 8'hC0);
        wr(1'b0, 8'h04, 8'h61);
        wr(1'b0, 8'h04, 8'h80);
        check8("frc_clr", status, 8'h00);
        force_timer_overflow = 1'b0;
        @(negedge clk);
        force_timer_overflow = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check8("frc_masked", status, 8'h00);
        wr(1'b0, 8'h04, 8'h00);
        force_timer_overflow = 1'b0;
        @(negedge clk);
        force_timer_overflow = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check8("frc_stopped", status, 8'h00);
        force_timer_overflow = 1'b0;

        // Timer 2 period: FE -> FF -> overflow on the 2nd tick320
        wr(1'b0, 8'h03, 8'hFE);
        wr(1'b0, 8'h04, 8'h42);
        cyc  = 0;
        n320 = 0;
        while (status !== 8'hA0 && cyc < 200) begin
            hit = (tb_pre == TICK - 1) && (tb_sub == 3);
            @(negedge clk);
            cyc++;
            if (hit) n320++;
        end
        check8("t2_status", status, 8'hA0);
        check8("t2_n320", n320[7:0], 8'd2);
        check8("t2_window", {7'b0, (cyc > 40 && cyc <= 80)}, 8'h01);
        wr(1'b0, 8'h04, 8'h80);
        check8("t2_rst", status, 8'h00);

        // mask during run: 4 masked ticks, then 4 unmasked ticks to the flag
        wr(1'b0, 8'h02, 8'hFC);
        wr(1'b0, 8'h04, 8'h41);
        for (int i = 0; i < 4; i++) begin
            wait_tick80();
            check8("msk_masked", status, 8'h00);
        end
        wr(1'b0, 8'h04, 8'h01);
        for (int i = 0; i < 3; i++) begin
            wait_tick80();
            check8("msk_counting", status, 8'h00);
        end
        wait_tick80();
        check8("msk_ovf", status, 8'hC0);

        // RST landing on the overflow tick
        wr(1'b0, 8'h04, 8'h00);
        wr(1'b0, 8'h04, 8'h80);
        check8("col_pre", status, 8'h00);
        wr(1'b0, 8'h02, 8'hFF);
        wr(1'b0, 8'h04, 8'h01);
        wait_pre(TICK - 1);
        wr(1'b0, 8'h04, 8'h80);
        check8("col_rst", status, 8'h00);
        wait_tick80();
        check8("col_next", status, 8'hC0);

        // asynchronous reset mid-count
        repeat (3) @(negedge clk);
        #1 ic_n = 1'b0;
        #1;
        check8("ic_status", status, 8'h00);
        check8("ic_irq_n", {7'b0, irq_n}, 8'h01);
        @(negedge clk);
        ic_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_tick80();
            check8("ic_idle", status, 8'h00);
        end

        // bank 1 writes are ignored
        wr(1'b0, 8'h02, 8'hFF);
        wr(1'b1, 8'h04, 8'h01);
        wait_tick80();
        wait_tick80();
        check8("bank1_ignored", status, 8'h00);
        wr(1'b0, 8'h04, 8'h01);
        wait_tick80();
        check8("bank0_start", status, 8'hC0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
